// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, read-allocate data cache in front of the SRAM controller.
// Optional hit/miss statistics counters are compiled in with `define CACHE_STATS_EN.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sramRdEn,
  output logic        sramWrEn,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  input  logic [63:0] sramReadData,
  input  logic        sramReady
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);

  localparam int unsigned Sets = 64;
  localparam logic [31:0] BaseAddr = 32'd1024;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrite} state_e;

  state_e state_q;

  logic [31:0] off;
  logic        word_sel;
  logic [5:0]  idx;
  logic [9:0]  tag;
  logic        unused_off;

  assign off        = address - BaseAddr;
  assign word_sel   = off[2];
  assign idx        = off[8:3];
  assign tag        = off[18:9];
  assign unused_off = ^{off[31:19], off[1:0]};

  // Storage arrays carry no reset; only valid and LRU bits are cleared.
  logic [63:0]     data_mem [2][Sets];
  logic [9:0]      tag_mem  [2][Sets];
  logic [Sets-1:0] valid_q  [2];
  logic [Sets-1:0] lru_q;

  logic        sram_rd_en_q;
  logic        sram_wr_en_q;
  logic        wr_hit_q;
  logic        wr_way_q;

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic [63:0] hit_block;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  logic        fill_way;
  logic        fill_en;
  logic        store_upd;

  assign hit0      = valid_q[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1      = valid_q[1][idx] && (tag_mem[1][idx] == tag);
  assign hit       = hit0 | hit1;
  assign hit_block = hit1 ? data_mem[1][idx] : data_mem[0][idx];
  assign hit_word  = word_sel ? hit_block[63:32] : hit_block[31:0];
  assign fill_word = word_sel ? sramReadData[63:32] : sramReadData[31:0];
  assign fill_way  = lru_q[idx];
  assign fill_en   = (state_q == StRdMiss) && sramReady;
  assign store_upd = (state_q == StWrite) && sramReady && wr_hit_q;

  assign sramRdEn      = sram_rd_en_q;
  assign sramWrEn      = sram_wr_en_q;
  assign sramAddress   = address;
  assign sramWriteData = writeData;

  always_comb begin
    ready    = 1'b1;
    readData = 32'd0;
    case (state_q)
      StIdle: begin
        if (wrEn) begin
          ready = 1'b0;
        end else if (rdEn) begin
          ready = hit;
          if (hit) readData = hit_word;
        end
      end
      StRdMiss: begin
        ready = sramReady;
        if (sramReady) readData = fill_word;
      end
      StWrite: begin
        ready = sramReady;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[fill_way][idx] <= sramReadData;
      tag_mem[fill_way][idx]  <= tag;
    end else if (store_upd) begin
      if (word_sel) data_mem[wr_way_q][idx][63:32] <= writeData;
      else          data_mem[wr_way_q][idx][31:0]  <= writeData;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
      wr_hit_q     <= 1'b0;
      wr_way_q     <= 1'b0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q    <= 16'd0;
      miss_cnt_q   <= 16'd0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (wrEn) begin
            state_q      <= StWrite;
            sram_wr_en_q <= 1'b1;
            // Hit status is captured at entry; the line is patched on completion.
            wr_hit_q     <= hit;
            wr_way_q     <= hit1;
          end else if (rdEn) begin
            if (hit) begin
              lru_q[idx] <= ~hit1;
`ifdef CACHE_STATS_EN
              if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
`endif
            end else begin
              state_q      <= StRdMiss;
              sram_rd_en_q <= 1'b1;
            end
          end
        end
        StRdMiss: begin
          if (sramReady) begin
            state_q                <= StIdle;
            sram_rd_en_q           <= 1'b0;
            valid_q[fill_way][idx] <= 1'b1;
            lru_q[idx]             <= ~fill_way;
`ifdef CACHE_STATS_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
          end
        end
        StWrite: begin
          if (sramReady) begin
            state_q      <= StIdle;
            sram_wr_en_q <= 1'b0;
            if (wr_hit_q) lru_q[idx] <= ~wr_way_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural SRAM responder and a read-data scoreboard.
// Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_cache_controller;

  localparam int SramLat = 4;

  logic        clk;
  logic        rst;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic        sramRdEn;
  logic        sramWrEn;
  logic [31:0] sramAddress;
  logic [31:0] sramWriteData;
  logic [63:0] sramReadData;
  logic        sramReady;
`ifdef CACHE_STATS_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .rdEn          (rdEn),
    .wrEn          (wrEn),
    .address       (address),
    .writeData     (writeData),
    .readData      (readData),
    .ready         (ready),
    .sramRdEn      (sramRdEn),
    .sramWrEn      (sramWrEn),
    .sramAddress   (sramAddress),
    .sramWriteData (sramWriteData),
    .sramReadData  (sramReadData),
    .sramReady     (sramReady)
`ifdef CACHE_STATS_EN
    ,
    .hitCount      (hitCount),
    .missCount     (missCount)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int tb_hits  = 0;
  int tb_misses = 0;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mrd(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (smem.exists(w)) return smem[w];
    return w ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_count", 64'(hitCount), 64'(tb_hits));
    check("miss_count", 64'(missCount), 64'(tb_misses));
`endif
  endtask

  // SRAM controller model: completes any request SramLat cycles after it is seen.
  initial begin
    int rcnt;
    logic [31:0] base;
    rcnt = 0;
    sramReady = 1'b0;
    sramReadData = 64'd0;
    forever begin
      @(negedge clk);
      if (sramReady) begin
        sramReady = 1'b0;
      end else if (sramRdEn || sramWrEn) begin
        rcnt++;
        if (rcnt == SramLat) begin
          rcnt = 0;
          sramReady = 1'b1;
          if (sramRdEn) begin
            base = sramAddress & ~32'h7;
            sramReadData = {mrd(base + 32'd4), mrd(base)};
          end
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit exp_hit);
    int cyc;
    logic [31:0] exp;
    @(negedge clk);
    address = a;
    rdEn = 1'b1;
    exp_q.push_back(mrd(a));
    #1;
    check("rd_ready_req", 64'(ready), 64'(exp_hit));
    if (exp_hit) begin
      check("rd_hit_no_sram", 64'(sramRdEn), 64'd0);
      exp = exp_q.pop_front();
      check("rd_hit_data", 64'(readData), 64'(exp));
      tb_hits++;
    end else begin
      cyc = 0;
      while (!ready && cyc < 30) begin
        @(negedge clk);
        #1;
        cyc++;
        check("rd_miss_sramrden", 64'(sramRdEn), 64'd1);
      end
      check("rd_miss_latency", 64'(cyc), 64'(SramLat));
      exp = exp_q.pop_front();
      if (ready) begin
        check("rd_miss_data", 64'(readData), 64'(exp));
        tb_misses++;
      end
    end
    @(negedge clk);
    rdEn = 1'b0;
    #1;
    check("rd_sramrden_low", 64'(sramRdEn), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
    int cyc;
    @(negedge clk);
    address = a;
    writeData = d;
    wrEn = 1'b1;
    rdEn = both;
    smem[a & ~32'h3] = d;
    #1;
    check("wr_ready_req", 64'(ready), 64'd0);
    cyc = 0;
    while (!ready && cyc < 30) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("wr_sramwren", 64'(sramWrEn), 64'd1);
        check("wr_no_sramrden", 64'(sramRdEn), 64'd0);
        check("wr_sramaddr", 64'(sramAddress), 64'(a));
        check("wr_sramdata", 64'(sramWriteData), 64'(d));
      end
    end
    check("wr_latency", 64'(cyc), 64'(SramLat));
    @(negedge clk);
    wrEn = 1'b0;
    rdEn = 1'b0;
    #1;
    check("wr_sramwren_low", 64'(sramWrEn), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rdEn = 1'b0;
    wrEn = 1'b0;
    address = 32'd1024;
    writeData = 32'd0;
    smem[32'd1024] = 32'hA;
    smem[32'd1028] = 32'hB;
    #1;
    check("rst_ready_idle", 64'(ready), 64'd1);
    check("rst_readdata", 64'(readData), 64'd0);
    check("rst_sramrden", 64'(sramRdEn), 64'd0);
    check("rst_sramwren", 64'(sramWrEn), 64'd0);
    check_stats();
    rdEn = 1'b1;
    address = 32'd2000;
    #1;
    check("rst_ready_req", 64'(ready), 64'd0);
    check("rst_addr_pass", 64'(sramAddress), 64'd2000);
    rdEn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_read(32'd1024, 1'b0);
    do_read(32'd1028, 1'b1);
    do_read(32'd1536, 1'b0);
    do_read(32'd2048, 1'b0);
    do_read(32'd1536, 1'b1);
    do_read(32'd1024, 1'b0);
    do_write(32'd1028, 32'h1234, 1'b0);
    do_read(32'd1028, 1'b1);
    do_write(32'd4096, 32'h7777_0001, 1'b0);
    do_read(32'd4096, 1'b0);
    do_write(32'd1024, 32'hCAFE, 1'b1);
    do_read(32'd1024, 1'b1);
    do_read(32'd1032, 1'b0);
    do_read(32'd1036, 1'b1);
    check_stats();

    // Reset in the middle of a fill abandons it.
    @(negedge clk);
    address = 32'd1040;
    rdEn = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    tb_hits = 0;
    tb_misses = 0;
    #1;
    check("rstmid_sramrden", 64'(sramRdEn), 64'd0);
    check("rstmid_ready", 64'(ready), 64'd0);
    check("rstmid_readdata", 64'(readData), 64'd0);
    check_stats();
    @(negedge clk);
    rdEn = 1'b0;
    #1;
    check("rstmid_ready_idle", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    do_read(32'd1032, 1'b0);
    do_read(32'd1036, 1'b1);
    do_read(32'd1032, 1'b1);
    do_read(32'd1036, 1'b1);
    check_stats();
    do_read(32'd1040, 1'b0);
    do_read(32'd1024, 1'b0);
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
